pc_fetch: RTL

PC_FETCH -- requirements
Module: pc_fetch

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/pc_fetch_if.sv | 33 +++
 rtl/add_16bit.sv | 17 +
 rtl/pc_fetch.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the CPU front end.
//   fetch_state_e  : fetch sequencer state encoding (FETCH / WAIT / HALT)
//   HLT_OPCODE_DEF : default opcode nibble (inst[15:12]) that stops fetch
//   PC_STEP        : byte distance between consecutive 16-bit instructions
//   is_opcode()    : helper comparing the opcode nibble of an instruction
// -----------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam logic [3:0]  HLT_OPCODE_DEF = 4'hF;
  localparam logic [15:0] PC_STEP        = 16'd2;

  // True when the top nibble of an instruction word matches the given opcode.
  function automatic logic is_opcode(input logic [15:0] inst,
                                     input logic [3:0]  op);
    return (inst[15:12] == op);
  endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// -----------------------------------------------------------------------------
// pc_fetch_if
// Request/response bus between the fetch unit and instruction memory.
//   imem_req  : fetch request, driven by the fetch unit
//   imem_addr : byte address of the request, meaningful while imem_req=1
//   imem_rdy  : memory returns imem_data this cycle
//   imem_data : fetched 16-bit instruction word
// Modports:
//   master : fetch unit side (drives req/addr, receives rdy/data)
//   slave  : memory side (receives req/addr, drives rdy/data)
// -----------------------------------------------------------------------------
interface pc_fetch_if;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_rdy;
  logic [15:0] imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdy,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdy,
    output imem_data
  );

endinterface

// File: rtl/add_16bit.sv
// -----------------------------------------------------------------------------
// add_16bit
// Plain 16-bit modular adder shared by datapath blocks. The carry out is
// dropped so that the sum wraps (16'hFFFE + 2 = 16'h0000).
//   a, b : addends
//   sum  : a + b modulo 2^16
// -----------------------------------------------------------------------------
module add_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  // Carry is intentionally discarded; callers rely on wrap-around.
  assign sum = a + b;

endmodule

// File: rtl/pc_fetch.sv
// -----------------------------------------------------------------------------
// pc_fetch
// Instruction fetch unit with a single-entry output buffer toward decode.
// Issues at most one memory request at a time, sustains one fetch per cycle
// when memory answers immediately, honours branch redirects with top
// priority, and stops permanently after decode accepts a HLT instruction.
//
// Parameters:
//   RESET_PC   : first fetch address after reset
//   HLT_OPCODE : inst[15:12] value that halts fetch
// Ports:
//   clk            : rising-edge clock
//   rst_n          : asynchronous active-low reset
//   imem           : instruction memory bus (master side)
//   inst_out       : buffered instruction to decode
//   inst_pc        : address of inst_out
//   inst_valid     : inst_out/inst_pc valid
//   stall          : decode cannot accept this cycle
//   redirect_valid : taken branch/jump resolved this cycle
//   redirect_pc    : branch target
//   halted         : fetch has stopped after an accepted HLT
// -----------------------------------------------------------------------------
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [3:0]  HLT_OPCODE = HLT_OPCODE_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  pc_fetch_if.master   imem,
  output logic [15:0]  inst_out,
  output logic [15:0]  inst_pc,
  output logic         inst_valid,
  input  logic         stall,
  input  logic         redirect_valid,
  input  logic [15:0]  redirect_pc,
  output logic         halted
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  inst_out_q, inst_out_d;
  logic [15:0]  inst_pc_q, inst_pc_d;
  logic         inst_valid_q, inst_valid_d;

  logic [15:0]  pc_plus2;
  logic         accept;
  logic         buf_free;
  logic         hlt_held;
  logic         fetch_req;
  logic         capture;

  // The sequential PC increment goes through the shared adder so the wrap
  // behaviour is the same as everywhere else in the datapath.
  add_16bit u_pc_inc (
    .a   (pc_q),
    .b   (PC_STEP),
    .sum (pc_plus2)
  );

  // Decode handshake terms. The buffer may be refilled in the same cycle it
  // is accepted, which is what gives one-fetch-per-cycle throughput. A HLT
  // sitting in the buffer blocks any further request, so nothing is fetched
  // past it unless a redirect flushes it.
  always_comb begin
    accept   = inst_valid_q & ~stall;
    buf_free = ~inst_valid_q | accept;
    hlt_held = inst_valid_q & is_opcode(inst_out_q, HLT_OPCODE);
    capture  = fetch_req & imem.imem_rdy;
  end

  // State, PC and output buffer registers. Everything returns to its reset
  // value asynchronously so an outstanding fetch is simply abandoned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      inst_out_q   <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_out_q   <= inst_out_d;
      inst_pc_q    <= inst_pc_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  // Next-state logic. Priority inside FETCH/WAIT is: redirect, then capture
  // of returned data, then HLT acceptance, then plain acceptance / waiting.
  // A capture and a HLT acceptance can never coincide because a held HLT
  // suppresses the request. WAIT is only entered with an empty buffer, so a
  // capture there never overwrites an unaccepted instruction.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    inst_out_d   = inst_out_q;
    inst_pc_d    = inst_pc_q;
    inst_valid_d = inst_valid_q;

    case (state_q)
      ST_FETCH, ST_WAIT: begin
        if (redirect_valid) begin
          pc_d         = redirect_pc;
          inst_valid_d = 1'b0;
          state_d      = ST_FETCH;
        end else if (capture) begin
          inst_out_d   = imem.imem_data;
          inst_pc_d    = pc_q;
          inst_valid_d = 1'b1;
          pc_d         = pc_plus2;
          state_d      = ST_FETCH;
        end else if (accept && hlt_held) begin
          inst_valid_d = 1'b0;
          state_d      = ST_HALT;
        end else begin
          if (accept) begin
            inst_valid_d = 1'b0;
          end
          if (fetch_req) begin
            state_d = ST_WAIT;
          end
        end
      end

      ST_HALT: begin
        inst_valid_d = 1'b0;
      end

      default: begin
        state_d      = ST_FETCH;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  // Output logic. The memory request is gated by rst_n so no request is
  // presented while reset is held, yet one appears as soon as it releases.
  always_comb begin
    fetch_req = 1'b0;
    case (state_q)
      ST_FETCH: fetch_req = buf_free & ~hlt_held & ~redirect_valid;
      ST_WAIT:  fetch_req = ~redirect_valid;
      default:  fetch_req = 1'b0;
    endcase

    imem.imem_req  = fetch_req & rst_n;
    imem.imem_addr = pc_q;
    inst_out       = inst_out_q;
    inst_pc        = inst_pc_q;
    inst_valid     = inst_valid_q;
    halted         = (state_q == ST_HALT);
  end

endmodule
